// File: rtl/th22d_cell.sv
// Registered NCL threshold-gate lanes: TH12, TH22 (C-element) and TH22D,
// plus completion reductions computed from the next-state lane vector.
module th22d_cell #(
   parameter int unsigned WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] th12_z,
   output logic [WIDTH-1:0] th22_z,
   output logic [WIDTH-1:0] th22d_z,
   output logic             th22_any,
   output logic             th22d_any,
   output logic             th22_all_null
);

   logic [WIDTH-1:0] th12_nxt;
   logic [WIDTH-1:0] th22_nxt;
   logic [WIDTH-1:0] th22d_nxt;
   logic             th22_any_nxt;
   logic             th22d_any_nxt;
   logic             th22_all_null_nxt;

   // Per-lane next state: set on both high, clear on both low, else hold
   always_comb begin
      th12_nxt          = a | b;
      th22_nxt          = (a & b) | (th22_z & (a | b));
      th22d_nxt         = (a & b) | (th22d_z & (a | b));
      th22_any_nxt      = |th22_nxt;
      th22d_any_nxt     = |th22d_nxt;
      th22_all_null_nxt = ~(|th22_nxt);
   end

   // Output registers with synchronous active-low reset (TH22D resets to DATA)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         th12_z        <= '0;
         th22_z        <= '0;
         th22d_z       <= '1;
         th22_any      <= 1'b0;
         th22d_any     <= 1'b1;
         th22_all_null <= 1'b1;
      end else begin
         th12_z        <= th12_nxt;
         th22_z        <= th22_nxt;
         th22d_z       <= th22d_nxt;
         th22_any      <= th22_any_nxt;
         th22d_any     <= th22d_any_nxt;
         th22_all_null <= th22_all_null_nxt;
      end
   end

endmodule

// File: tb/tb_th22d_cell.sv
// Self-checking bench for th22d_cell: directed scenarios then random traffic
// compared against a per-lane behavioural threshold-gate model.
module tb_th22d_cell;

   localparam int unsigned W = 2;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] th12_z;
   logic [W-1:0] th22_z;
   logic [W-1:0] th22d_z;
   logic         th22_any;
   logic         th22d_any;
   logic         th22_all_null;

   // reference model state
   logic [W-1:0] m12;
   logic [W-1:0] m22;
   logic [W-1:0] m22d;

   int vectors;
   int miscompares;

   th22d_cell #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .a            (a),
      .b            (b),
      .th12_z       (th12_z),
      .th22_z       (th22_z),
      .th22d_z      (th22d_z),
      .th22_any     (th22_any),
      .th22d_any    (th22d_any),
      .th22_all_null(th22_all_null)
   );

   // free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // threshold-gate behaviour per lane, advanced once per rising edge
   task automatic model_edge(input logic r, input logic [W-1:0] ai, input logic [W-1:0] bi);
      if (!r) begin
         m12  = '0;
         m22  = '0;
         m22d = '1;
      end else begin
         for (int i = 0; i < int'(W); i++) begin
            int ones;
            ones = int'(ai[i]) + int'(bi[i]);
            m12[i] = (ones >= 1);
            if (ones == 2) begin
               m22[i]  = 1'b1;
               m22d[i] = 1'b1;
            end else if (ones == 0) begin
               m22[i]  = 1'b0;
               m22d[i] = 1'b0;
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      logic any22, any22d, null22;
      any22  = 1'b0;
      any22d = 1'b0;
      null22 = 1'b1;
      for (int i = 0; i < int'(W); i++) begin
         if (m22[i])  any22  = 1'b1;
         if (m22d[i]) any22d = 1'b1;
         if (m22[i])  null22 = 1'b0;
      end
      chk({tag, ".th12"},  th12_z,  m12);
      chk({tag, ".th22"},  th22_z,  m22);
      chk({tag, ".th22d"}, th22d_z, m22d);
      chk({tag, ".any22"},  W'(th22_any),      W'(any22));
      chk({tag, ".any22d"}, W'(th22d_any),     W'(any22d));
      chk({tag, ".null22"}, W'(th22_all_null), W'(null22));
   endtask

   // apply one input vector across one rising edge and check all outputs
   task automatic step(input string tag, input logic r, input logic [W-1:0] ai, input logic [W-1:0] bi);
      @(negedge clk);
      rst_n = r;
      a     = ai;
      b     = bi;
      @(posedge clk);
      #1;
      model_edge(r, ai, bi);
      check_all(tag);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n = 1'b0;
      a     = '0;
      b     = '0;
      m12   = '0;
      m22   = '0;
      m22d  = '1;

      // reset with inputs high: reset dominates
      step("rst0", 1'b0, 2'b11, 2'b11);
      step("rst1", 1'b0, 2'b11, 2'b11);
      chk("rst.th22_const",  th22_z,  2'b00);
      chk("rst.th22d_const", th22d_z, 2'b11);
      chk("rst.null_const",  W'(th22_all_null), 2'b01);

      // TH22 set / hold / clear
      step("t22a", 1'b1, 2'b11, 2'b01);
      chk("t22a.const", th22_z, 2'b01);
      step("t22b", 1'b1, 2'b10, 2'b01);
      chk("t22b.const", th22_z, 2'b01);
      step("t22c", 1'b1, 2'b00, 2'b00);
      chk("t22c.const", th22_z, 2'b00);

      // TH22D holds DATA after reset with mixed inputs, then clears
      step("r2", 1'b0, 2'b00, 2'b00);
      for (int k = 0; k < 3; k++) begin
         step("t22d_hold", 1'b1, 2'b01, 2'b10);
         chk("t22d_hold.const", th22d_z, 2'b11);
      end
      step("t22d_clr", 1'b1, 2'b00, 2'b00);
      chk("t22d_clr.const", th22d_z, 2'b00);
      chk("t22d_clr.any",   W'(th22d_any), 2'b00);

      // TH12 has no hysteresis
      step("t12a", 1'b1, 2'b01, 2'b00);
      chk("t12a.const", th12_z, 2'b01);
      step("t12b", 1'b1, 2'b00, 2'b10);
      chk("t12b.const", th12_z, 2'b10);
      step("t12c", 1'b1, 2'b00, 2'b00);
      chk("t12c.const", th12_z, 2'b00);

      // reset in the middle of a hold
      step("mid_set",  1'b1, 2'b11, 2'b11);
      step("mid_hold", 1'b1, 2'b01, 2'b10);
      chk("mid_hold.const", th22_z, 2'b11);
      step("mid_rst",  1'b0, 2'b01, 2'b10);
      chk("mid_rst.th22",  th22_z,  2'b00);
      chk("mid_rst.th22d", th22d_z, 2'b11);

      // randomized traffic with occasional resets
      for (int n = 0; n < 1000; n++) begin
         step("rand", ($urandom_range(15) != 0), W'($urandom), W'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/th22d_cell.md
TH22D_CELL -- requirements
Module: th22d_cell

Interface
REQ-001 Parameter WIDTH, default 2, meaning number of independent gate lanes (one dual-rail signal = 2 lanes); legal range 1..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 a  input  WIDTH  first threshold input per lane.
REQ-005 b  input  WIDTH  second threshold input per lane (e.g. enable/acknowledge).
REQ-006 th12_z  output  WIDTH  registered TH12 result per lane.
REQ-007 th22_z  output  WIDTH  registered TH22 (C-element) result per lane; resets to NULL (0).
REQ-008 th22d_z  output  WIDTH  registered TH22D result per lane; resets to DATA (1).
REQ-009 th22_any  output  1  registered TH12-style completion: OR of all th22_z lanes.
REQ-010 th22d_any  output  1  registered OR of all th22d_z lanes.
REQ-011 th22_all_null  output  1  registered; 1 when every th22_z lane is 0.

Function
REQ-012 Each lane i is evaluated independently; no cross-lane logic except the reduction outputs.
REQ-013 TH12 lane: th12_z[i] next = a[i] | b[i]; no hysteresis, no held state.
REQ-014 TH22 lane: if a[i]=1 and b[i]=1, th22_z[i] next = 1; if a[i]=0 and b[i]=0, next = 0; otherwise next = current value (hold).
REQ-015 TH22D lane: identical set/clear/hold rule to TH22; differs only in reset value (1).
REQ-016 Latency: one clk from input sample to output; inputs sampled on rising edge N appear on outputs after edge N.
REQ-017 Reduction outputs use the next-state lane values, so they change on the same edge as the lanes (no extra cycle).
REQ-018 th22_any and th22_all_null are never both 1; both derive from the same next-state vector.
REQ-019 Mixed inputs (a!=b) on a TH22/TH22D lane hold the lane for any number of cycles.
REQ-020 Hysteresis: a lane at 1 with inputs 1,1 -> 1,0 -> 0,1 stays 1 until inputs are 0,0; a lane at 0 stays 0 until inputs are 1,1.
REQ-021 No X propagation from outputs after the first reset; inputs are treated as 2-state.
REQ-022 Output registers are plain flip-flops; no combinational path from a/b to any output.

Reset
REQ-023 While rst_n=0 at a rising clk edge: th12_z=0, th22_z=0, th22d_z=all 1, th22_any=0, th22d_any=1, th22_all_null=1.
REQ-024 Reset takes priority over a/b on that edge, including mid-hold (mixed inputs) states.
REQ-025 First non-reset edge after rst_n returns to 1 applies REQ-013..REQ-015 normally from the reset state; e.g. TH22D lane with mixed inputs keeps 1, with 0,0 clears to 0.
REQ-026 Before the first reset edge, output values are undefined; bench checks begin after reset.

Verification
REQ-027 Reset: rst_n=0 for 2 cycles, a=2'b11, b=2'b11 -> th22_z=00, th22d_z=11, th12_z=00, th22_all_null=1, th22d_any=1.
REQ-028 TH22 set/hold/clear, WIDTH=2: from reset, a=11,b=01 -> th22_z=01; a=10,b=01 -> th22_z=01 (hold); a=00,b=00 -> th22_z=00, th22_all_null=1.
REQ-029 TH22D hold after reset: release rst_n with a=01,b=10 -> th22d_z=11 for 3 cycles; then a=00,b=00 -> th22d_z=00, th22d_any=0.
REQ-030 TH12: a=01,b=00 -> th12_z=01; a=00,b=10 -> th12_z=10; a=00,b=00 -> th12_z=00, each one cycle after the input is applied.
REQ-031 Reset mid-operation: lanes at th22_z=11 with mixed inputs held; assert rst_n=0 one edge -> th22_z=00, th22d_z=11 on that edge.
REQ-032 Randomized check: 1000 cycles of random a/b/rst_n against a per-lane reference model of REQ-013..REQ-025; zero mismatches.
